// File: rtl/alu_sequencer_if.sv
// Command/result handshake bundle between a command source and alu_sequencer.
//   cmd_valid/cmd_ready : command handshake; cmd_op/cmd_data/cmd_rep payload
//   res_valid/res_ready : result handshake; res_data/res_err payload
// master = command source / result sink, slave = sequencer.
interface alu_sequencer_if #(
   parameter int unsigned REP_W = 4
) ();
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [7:0]       cmd_data;
   logic [REP_W-1:0] cmd_rep;
   logic             res_valid;
   logic             res_ready;
   logic [7:0]       res_data;
   logic             res_err;

   modport master (
      output cmd_valid, cmd_op, cmd_data, cmd_rep, res_ready,
      input  cmd_ready, res_valid, res_data, res_err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, cmd_rep, res_ready,
      output cmd_ready, res_valid, res_data, res_err
   );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences one command at a time into an external accumulator ALU: drives
// the ALU opcode/operand/strobes for N back-to-back cycles, captures the
// accumulator and returns it through a valid/ready result handshake.
// Ports:
//   Clk, RST            : clock, asynchronous active-low reset
//   bus (slave)         : command and result handshakes
//   alu_dout            : ALU accumulator value
//   BusOut, alu_op      : operand and opcode driven to the ALU
//   Wen, INC, alu_rst   : ALU load / increment / synchronous-clear strobes
//   busy                : high whenever the sequencer is not idle

// Fallback opcode values, used only when the shared ALU defines are absent.
`ifndef ALU_NONE
`define ALU_NONE 3'd0
`endif
`ifndef ALU_ADD
`define ALU_ADD 3'd1
`endif
`ifndef ALU_MUL
`define ALU_MUL 3'd2
`endif
`ifndef ALU_DIV
`define ALU_DIV 3'd3
`endif
`ifndef ALU_MOD
`define ALU_MOD 3'd4
`endif

module alu_sequencer #(
   parameter int unsigned REP_W = 4
) (
   input  logic       Clk,
   input  logic       RST,
   alu_sequencer_if.slave bus,
   input  logic [7:0] alu_dout,
   output logic [7:0] BusOut,
   output logic [2:0] alu_op,
   output logic       Wen,
   output logic       INC,
   output logic       alu_rst,
   output logic       busy
);

   localparam logic [2:0] OP_LOAD = 3'd0;
   localparam logic [2:0] OP_ADD  = 3'd1;
   localparam logic [2:0] OP_MUL  = 3'd2;
   localparam logic [2:0] OP_DIV  = 3'd3;
   localparam logic [2:0] OP_MOD  = 3'd4;
   localparam logic [2:0] OP_INC  = 3'd5;
   localparam logic [2:0] OP_CLR  = 3'd6;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_CAPTURE,
      S_DONE
   } state_t;

   state_t           state_q;
   logic [REP_W-1:0] rem_q;
   logic             cmd_ready_q;
   logic             res_valid_q;
   logic [7:0]       res_data_q;
   logic             res_err_q;

   logic [2:0]       stim_op_c;
   logic             stim_wen_c;
   logic             stim_inc_c;
   logic             stim_rst_c;
   logic             single_c;
   logic             div0_c;
   logic             read_c;
   logic [REP_W-1:0] rep_c;

   assign bus.cmd_ready = cmd_ready_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = res_data_q;
   assign bus.res_err   = res_err_q;

   // Decode the offered command into ALU stimulus and sequencing attributes.
   always_comb begin
      stim_op_c  = `ALU_NONE;
      stim_wen_c = 1'b0;
      stim_inc_c = 1'b0;
      stim_rst_c = 1'b0;
      single_c   = 1'b0;
      div0_c     = 1'b0;
      read_c     = 1'b0;
      case (bus.cmd_op)
         OP_LOAD: begin
            stim_wen_c = 1'b1;
            single_c   = 1'b1;
         end
         OP_ADD: stim_op_c = `ALU_ADD;
         OP_MUL: stim_op_c = `ALU_MUL;
         OP_DIV: begin
            stim_op_c = `ALU_DIV;
            div0_c    = (bus.cmd_data == 8'h00);
         end
         OP_MOD: begin
            stim_op_c = `ALU_MOD;
            div0_c    = (bus.cmd_data == 8'h00);
         end
         OP_INC: stim_inc_c = 1'b1;
         OP_CLR: begin
            stim_rst_c = 1'b1;
            single_c   = 1'b1;
         end
         default: read_c = 1'b1;
      endcase
      // A repeat count of zero is treated as one; LOAD/CLR always run once.
      if (single_c || (bus.cmd_rep == '0)) rep_c = REP_W'(1);
      else                                 rep_c = bus.cmd_rep;
   end

   // Sequencer FSM with registered ALU stimulus and handshake outputs.
   always_ff @(posedge Clk or negedge RST) begin
      if (!RST) begin
         state_q     <= S_IDLE;
         rem_q       <= '0;
         cmd_ready_q <= 1'b1;
         busy        <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= 8'h00;
         res_err_q   <= 1'b0;
         BusOut      <= 8'h00;
         alu_op      <= `ALU_NONE;
         Wen         <= 1'b0;
         INC         <= 1'b0;
         alu_rst     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.cmd_valid && cmd_ready_q) begin
                  cmd_ready_q <= 1'b0;
                  busy        <= 1'b1;
                  res_err_q   <= div0_c;
                  if (read_c || div0_c) begin
                     // Nothing to issue: report the accumulator as it stands.
                     rem_q   <= '0;
                     state_q <= S_CAPTURE;
                  end else begin
                     rem_q   <= rep_c;
                     BusOut  <= bus.cmd_data;
                     alu_op  <= stim_op_c;
                     Wen     <= stim_wen_c;
                     INC     <= stim_inc_c;
                     alu_rst <= stim_rst_c;
                     state_q <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               rem_q <= rem_q - REP_W'(1);
               // Stimulus holds for further repeats; drop it after the last one.
               if (rem_q <= REP_W'(1)) begin
                  BusOut  <= 8'h00;
                  alu_op  <= `ALU_NONE;
                  Wen     <= 1'b0;
                  INC     <= 1'b0;
                  alu_rst <= 1'b0;
                  state_q <= S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               res_data_q  <= alu_dout;
               res_valid_q <= 1'b1;
               state_q     <= S_DONE;
            end
            S_DONE: begin
               if (res_valid_q && bus.res_ready) begin
                  res_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  busy        <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer paired with a behavioural accumulator ALU.
// Expected results come from a bench-side accumulator model and flow through
// a scoreboard queue that is popped when the sequencer presents a result.

`ifndef ALU_NONE
`define ALU_NONE 3'd0
`endif
`ifndef ALU_ADD
`define ALU_ADD 3'd1
`endif
`ifndef ALU_MUL
`define ALU_MUL 3'd2
`endif
`ifndef ALU_DIV
`define ALU_DIV 3'd3
`endif
`ifndef ALU_MOD
`define ALU_MOD 3'd4
`endif

module tb_alu_sequencer;
   localparam int unsigned REP_W = 4;

   localparam logic [2:0] C_LOAD = 3'd0;
   localparam logic [2:0] C_ADD  = 3'd1;
   localparam logic [2:0] C_MUL  = 3'd2;
   localparam logic [2:0] C_DIV  = 3'd3;
   localparam logic [2:0] C_MOD  = 3'd4;
   localparam logic [2:0] C_INC  = 3'd5;
   localparam logic [2:0] C_CLR  = 3'd6;
   localparam logic [2:0] C_READ = 3'd7;

   logic       Clk = 1'b0;
   logic       RST = 1'b0;
   logic [7:0] alu_dout;
   logic [7:0] BusOut;
   logic [2:0] alu_op;
   logic       Wen;
   logic       INC;
   logic       alu_rst;
   logic       busy;

   always #5 Clk = ~Clk;

   alu_sequencer_if #(.REP_W(REP_W)) bus ();

   alu_sequencer #(.REP_W(REP_W)) dut (
      .Clk      (Clk),
      .RST      (RST),
      .bus      (bus.slave),
      .alu_dout (alu_dout),
      .BusOut   (BusOut),
      .alu_op   (alu_op),
      .Wen      (Wen),
      .INC      (INC),
      .alu_rst  (alu_rst),
      .busy     (busy)
   );

   // Behavioural ALU: accumulator is not touched by the sequencer reset.
   logic [7:0] acc = 8'h00;
   assign alu_dout = acc;
   always @(posedge Clk) begin
      if (alu_rst)      acc <= 8'h00;
      else if (Wen)     acc <= BusOut;
      else if (INC)     acc <= acc + 8'h01;
      else begin
         case (alu_op)
            `ALU_ADD: acc <= acc + BusOut;
            `ALU_MUL: acc <= acc * BusOut;
            `ALU_DIV: acc <= (BusOut == 8'h00) ? acc : acc / BusOut;
            `ALU_MOD: acc <= (BusOut == 8'h00) ? acc : acc % BusOut;
            default:  acc <= acc;
         endcase
      end
   end

   typedef struct packed {
      logic [7:0] d;
      logic       e;
   } exp_t;

   exp_t       sb[$];
   int         n_cmp  = 0;
   int         n_fail = 0;
   logic [7:0] model_acc = 8'h00;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [5:0] enc(input logic [2:0] op);
      case (op)
         C_LOAD:  enc = {`ALU_NONE, 3'b100};
         C_ADD:   enc = {`ALU_ADD,  3'b000};
         C_MUL:   enc = {`ALU_MUL,  3'b000};
         C_DIV:   enc = {`ALU_DIV,  3'b000};
         C_MOD:   enc = {`ALU_MOD,  3'b000};
         C_INC:   enc = {`ALU_NONE, 3'b010};
         C_CLR:   enc = {`ALU_NONE, 3'b001};
         default: enc = {`ALU_NONE, 3'b000};
      endcase
   endfunction

   // Advance the bench accumulator model and push the expected result.
   task automatic model_push(input logic [2:0] op, input logic [7:0] data,
                             input logic [REP_W-1:0] rep, output int n_issue);
      int   n;
      logic err;
      n   = (rep == '0) ? 1 : int'(rep);
      err = 1'b0;
      case (op)
         C_LOAD: begin model_acc = data; n_issue = 1; end
         C_ADD:  begin for (int j = 0; j < n; j++) model_acc = model_acc + data; n_issue = n; end
         C_MUL:  begin for (int j = 0; j < n; j++) model_acc = model_acc * data; n_issue = n; end
         C_DIV, C_MOD: begin
            if (data == 8'h00) begin
               err = 1'b1; n_issue = 0;
            end else begin
               for (int j = 0; j < n; j++)
                  model_acc = (op == C_DIV) ? model_acc / data : model_acc % data;
               n_issue = n;
            end
         end
         C_INC:  begin for (int j = 0; j < n; j++) model_acc = model_acc + 8'h01; n_issue = n; end
         C_CLR:  begin model_acc = 8'h00; n_issue = 1; end
         default: n_issue = 0;
      endcase
      sb.push_back({model_acc, err});
   endtask

   // Called at a negedge; returns at a negedge after the result handshake.
   task automatic run_cmd(input string tag, input logic [2:0] op, input logic [7:0] data,
                          input logic [REP_W-1:0] rep, input int hold);
      int   n_issue, lat, seen, enc_bad, excl_bad;
      exp_t e;
      model_push(op, data, rep, n_issue);
      chk({tag, "/cmd_ready"}, 16'(bus.cmd_ready), 16'(1'b1));
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_data  = data;
      bus.cmd_rep   = rep;
      lat = 0; seen = 0; enc_bad = 0; excl_bad = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge Clk);
         if (i == 1) bus.cmd_valid = 1'b0;
         if ($countones({Wen, INC, alu_rst}) > 1) excl_bad++;
         if (bus.res_valid) begin
            lat = i;
            break;
         end
         if (alu_op != `ALU_NONE || Wen || INC || alu_rst) begin
            seen++;
            if ({alu_op, Wen, INC, alu_rst} !== enc(op) || BusOut !== data) enc_bad++;
         end else if (BusOut !== 8'h00) begin
            enc_bad++;
         end
      end
      chk({tag, "/latency"}, 16'(lat), 16'(n_issue + 2));
      chk({tag, "/issue_cycles"}, 16'(seen), 16'(n_issue));
      chk({tag, "/issue_encoding"}, 16'(enc_bad), 16'(0));
      chk({tag, "/one_strobe"}, 16'(excl_bad), 16'(0));
      if (sb.size() == 0) begin
         chk({tag, "/scoreboard_empty"}, 16'(sb.size()), 16'(1));
         return;
      end
      e = sb.pop_front();
      if (lat == 0) return;
      chk({tag, "/res_data"}, 16'(bus.res_data), 16'(e.d));
      chk({tag, "/res_err"}, 16'(bus.res_err), 16'(e.e));
      for (int h = 0; h < hold; h++) begin
         bus.cmd_valid = 1'b1;
         bus.cmd_op    = C_CLR;
         @(negedge Clk);
         chk({tag, "/hold_valid"}, 16'(bus.res_valid), 16'(1'b1));
         chk({tag, "/hold_data"}, 16'(bus.res_data), 16'(e.d));
         chk({tag, "/hold_ready"}, 16'(bus.cmd_ready), 16'(1'b0));
         chk({tag, "/hold_stim"}, 16'({alu_op, Wen, INC, alu_rst}), 16'({`ALU_NONE, 3'b000}));
      end
      bus.cmd_valid = 1'b0;
      bus.res_ready = 1'b1;
      @(negedge Clk);
      bus.res_ready = 1'b0;
      chk({tag, "/after_valid"}, 16'(bus.res_valid), 16'(1'b0));
      chk({tag, "/after_ready"}, 16'(bus.cmd_ready), 16'(1'b1));
      chk({tag, "/after_busy"}, 16'(busy), 16'(1'b0));
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 3'd0;
      bus.cmd_data  = 8'h00;
      bus.cmd_rep   = '0;
      bus.res_ready = 1'b0;

      // Reset state
      repeat (3) @(negedge Clk);
      chk("rst/cmd_ready", 16'(bus.cmd_ready), 16'(1'b1));
      chk("rst/busy", 16'(busy), 16'(1'b0));
      chk("rst/res_valid", 16'(bus.res_valid), 16'(1'b0));
      chk("rst/res_data", 16'(bus.res_data), 16'(8'h00));
      chk("rst/res_err", 16'(bus.res_err), 16'(1'b0));
      chk("rst/stim", 16'({BusOut, alu_op, Wen, INC, alu_rst}), 16'({8'h00, `ALU_NONE, 3'b000}));

      // First command offered together with reset release
      RST = 1'b1;
      run_cmd("load05", C_LOAD, 8'h05, 4'd0, 0);
      run_cmd("add03", C_ADD, 8'h03, 4'd1, 0);
      run_cmd("load02", C_LOAD, 8'h02, 4'd0, 0);
      run_cmd("mul03x4", C_MUL, 8'h03, 4'd4, 0);
      run_cmd("loadC8", C_LOAD, 8'hC8, 4'd0, 0);
      run_cmd("add64", C_ADD, 8'h64, 4'd0, 0);
      run_cmd("inc_rep0", C_INC, 8'h00, 4'd0, 0);
      run_cmd("div0", C_DIV, 8'h00, 4'd3, 0);
      run_cmd("mod07", C_MOD, 8'h07, 4'd1, 0);
      run_cmd("mod0", C_MOD, 8'h00, 4'd2, 0);
      run_cmd("load11_rep5", C_LOAD, 8'h11, 4'd5, 0);
      run_cmd("clr_rep7", C_CLR, 8'h00, 4'd7, 0);
      run_cmd("read0", C_READ, 8'h00, 4'd0, 0);
      run_cmd("add10x15", C_ADD, 8'h10, 4'd15, 0);
      run_cmd("inc_x3", C_INC, 8'h00, 4'd3, 0);
      run_cmd("div03x2", C_DIV, 8'h03, 4'd2, 0);
      run_cmd("load07", C_LOAD, 8'h07, 4'd0, 0);

      // Reset during the third ISSUE cycle of MUL 0x01 x8
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = C_MUL;
      bus.cmd_data  = 8'h01;
      bus.cmd_rep   = 4'd8;
      @(negedge Clk);
      bus.cmd_valid = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
      chk("mrst/issuing", 16'(alu_op), 16'(`ALU_MUL));
      RST = 1'b0;
      #1;
      chk("mrst/stim", 16'({BusOut, alu_op, Wen, INC, alu_rst}), 16'({8'h00, `ALU_NONE, 3'b000}));
      chk("mrst/busy", 16'(busy), 16'(1'b0));
      chk("mrst/res_valid", 16'(bus.res_valid), 16'(1'b0));
      chk("mrst/cmd_ready", 16'(bus.cmd_ready), 16'(1'b1));
      @(negedge Clk);
      RST = 1'b1;
      repeat (3) begin
         @(negedge Clk);
         chk("mrst/no_result", 16'(bus.res_valid), 16'(1'b0));
         chk("mrst/ready_after", 16'(bus.cmd_ready), 16'(1'b1));
      end

      // Accumulator survives the sequencer reset; stall DONE for 5 cycles
      run_cmd("read_hold5", C_READ, 8'h00, 4'd0, 5);
      run_cmd("read_after_hold", C_READ, 8'h00, 4'd0, 0);

      chk("scoreboard_drained", 16'(sb.size()), 16'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
